bcd_multi_counter: RTL and testbench
====================================

Name: bcd_multi_counter

Overview:
- Parametrised N-digit BCD up/down counter with synchronous clear, parallel load, count enable and direction control.
- Digit carry/borrow ripples combinationally inside one cycle, so the full multi-digit value updates every enabled clock.
- Registered wrap and load-error pulses feed downstream timer/display logic; value drives the 7-seg multiplexer.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); value width = 4*NUM_DIGITS.
- STEP_ONE_ONLY, 1, reserved; the counter always steps by exactly 1 LSD count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear to all-zero.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  4*NUM_DIGITS  BCD value to load; digit 0 in [3:0].
- en  input  1  count enable, one step per enabled cycle.
- dir  input  1  1 = up, 0 = down.
- value  output  4*NUM_DIGITS  current BCD count, registered.
- wrap  output  1  one-cycle pulse, registered: count passed a full-range boundary.
- load_err  output  1  one-cycle pulse, registered: load_val held a nibble > 9.
- is_zero  output  1  combinational: value == all-zero.

Behaviour:
- Reset (rst_n low, async): value = 0, wrap = 0, load_err = 0. Release takes effect at the next clk edge.
- Priority per cycle: clr > load > en. Lower-priority requests in the same cycle are dropped; nothing is queued.
- clr: value <= 0. wrap <= 0. load_err <= 0.
- load: each nibble > 9 loads as 9; every nibble <= 9 loads as given.
  - load_err <= 1 if any nibble was > 9, else 0.
  - wrap <= 0.
- en, up: digit 0 increments.
  - A digit at 9 goes to 0 and generates a carry into the next digit.
  - Digit k changes only if all lower digits were 9.
- en, down: digit 0 decrements.
  - A digit at 0 goes to 9 and generates a borrow.
  - Digit k changes only if all lower digits were 0.
- Full-range wrap:
  - Up from all-9 (e.g. 9999) gives 0000 with wrap = 1.
  - Down from 0000 gives 9999 with wrap = 1.
  - wrap rises in the same cycle the wrapped value appears on value.
- Idle (no clr/load/en): value holds; wrap = 0, load_err = 0.
- Latency: 1 clock from a qualifying input to the value/wrap/load_err update.
- dir may change every cycle; only the level sampled on the enabled edge matters.
- Internal digit registers never hold codes > 9 in any reachable state.
- Reset asserted mid-count forces the reset state immediately; pending pulses are lost.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined:
  - Up at all-9 holds all-9; down at 0000 holds 0000.
  - wrap is renamed in meaning to "saturated hit": it pulses on each enabled cycle in which a step was blocked.
  - clr and load are unaffected.
- Undefined: wrap-around behaviour as above.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - typedef bcd_digit_t (4-bit logic).
  - function bcd_clamp (nibble > 9 -> 9).
- Sub-module bcd_digit_cell:
  - Combinational next-digit logic per digit.
  - Inputs: cur, step_in, dir. Outputs: nxt, step_out.
  - step_out = step_in & (dir ? cur==9 : cur==0).
  - Instantiated NUM_DIGITS times in a generate chain; step_in of digit 0 = en.
- Top holds the registers, the priority mux and the pulse generation.

Test Plan (NUM_DIGITS=4):
- Reset released, 3 cycles en=1 dir=1 -> value 0003, wrap 0, is_zero 0.
- load 0x0199, then en=1 dir=1 one cycle -> value 0200; next cycle down -> 0199.
- load 0x9999, en=1 dir=1 -> value 0000 and wrap=1 for exactly one cycle; is_zero=1.
  - With BCD_SATURATE_EN: value stays 9999, wrap=1.
- value 0000, en=1 dir=0 -> 9999, wrap=1.
  - With BCD_SATURATE_EN: value stays 0000, wrap=1.
- load 0x3A7F -> value 3979, load_err=1 one cycle, wrap 0.
- clr=1 load=1 en=1 same cycle from 4321 -> value 0000.
  - Then load=1 en=1 with load_val 0x0055 -> value 0055, not 0056.
  - Assert rst_n low mid-count -> value 0000 immediately, without waiting for clk.

Source files
------------

// File: rtl/bcd_multi_counter_pkg.sv
// bcd_multi_counter_pkg: shared BCD digit type, digit limits and load clamp helper.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_multi_counter_if.sv
// bcd_multi_counter_if: control/load requests from the master, count and status pulses back from the counter.
interface bcd_multi_counter_if #(parameter int NUM_DIGITS = 4);
    logic                    clr;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    en;
    logic                    dir;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    wrap;
    logic                    load_err;
    logic                    is_zero;
    modport master (output clr, load, load_val, en, dir, input value, wrap, load_err, is_zero);
    modport slave  (input clr, load, load_val, en, dir, output value, wrap, load_err, is_zero);
endinterface

// File: rtl/bcd_multi_counter_digit_cell.sv
// bcd_digit_cell: combinational next-digit and carry/borrow for one BCD digit of the ripple chain.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t cur,
    input  logic       step_in,
    input  logic       dir,
    output bcd_digit_t nxt,
    output logic       step_out
);
    logic at_edge;
    assign at_edge  = dir ? (cur == BCD_MAX) : (cur == BCD_MIN);
    assign step_out = step_in & at_edge;
    assign nxt      = !step_in ? cur :
                      at_edge  ? (dir ? BCD_MIN : BCD_MAX) :
                      dir      ? cur + 4'd1 : cur - 4'd1;
endmodule

// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter: N-digit BCD up/down counter with clear, clamped load, wrap and load-error pulses.
// Build with BCD_SATURATE_EN to hold at the range ends instead of wrapping.
module bcd_multi_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STEP_ONE_ONLY = 1
) (
    input logic clk,
    input logic rst_n,
    bcd_multi_counter_if.slave bus
);
    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0]        value_q, stepped, loaded, count_next;
    logic [NUM_DIGITS:0] carry;
    logic                wrap_q, err_q, bad, hit;
    logic                unused_step_param;

    assign unused_step_param = |STEP_ONE_ONLY;
    assign carry[0] = bus.en;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .cur      (value_q[4*i +: 4]),
            .step_in  (carry[i]),
            .dir      (bus.dir),
            .nxt      (stepped[4*i +: 4]),
            .step_out (carry[i+1])
        );
    end

    // A carry/borrow out of the top digit means the whole range was crossed.
    assign hit = carry[NUM_DIGITS];

`ifdef BCD_SATURATE_EN
    assign count_next = hit ? value_q : stepped;
`else
    assign count_next = stepped;
`endif

    always_comb begin
        loaded = '0;
        bad    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            loaded[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
            bad = bad | (bus.load_val[4*i +: 4] > BCD_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            value_q <= bus.clr ? '0 : bus.load ? loaded : count_next;
            wrap_q  <= !bus.clr && !bus.load && hit;
            err_q   <= !bus.clr && bus.load && bad;
        end
    end

    assign bus.value    = value_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = err_q;
    assign bus.is_zero  = (value_q == '0);
endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb_bcd_multi_counter: directed plus random stimulus against a decimal-integer model of the counter.
module tb_bcd_multi_counter;
    localparam int ND   = 4;
    localparam int MAXV = 9999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mv = 0;
    logic mw = 1'b0;
    logic me = 1'b0;

    bcd_multi_counter_if #(.NUM_DIGITS(ND)) bus ();

    bcd_multi_counter #(.NUM_DIGITS(ND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [4*ND-1:0] b);
        int v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + ((b[4*i +: 4] > 9) ? 9 : int'(b[4*i +: 4]));
        return v;
    endfunction

    function automatic logic [4*ND-1:0] int2bcd(input int v);
        logic [4*ND-1:0] b = '0;
        for (int i = 0; i < ND; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    function automatic logic any_bad(input logic [4*ND-1:0] b);
        logic r = 1'b0;
        for (int i = 0; i < ND; i++) r = r | (b[4*i +: 4] > 9);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".value"}, 32'(bus.value), 32'(int2bcd(mv)));
        chk({tag, ".wrap"}, 32'(bus.wrap), 32'(mw));
        chk({tag, ".load_err"}, 32'(bus.load_err), 32'(me));
        chk({tag, ".is_zero"}, 32'(bus.is_zero), 32'(mv == 0));
    endtask

    // Drive one cycle of requests, advance the model by the same rules, check 1ns after the edge.
    task automatic cyc(input string tag, input logic c, input logic l, input logic [4*ND-1:0] lv,
                       input logic e, input logic d);
        bus.clr = c; bus.load = l; bus.load_val = lv; bus.en = e; bus.dir = d;
        @(posedge clk);
        mw = 1'b0;
        me = 1'b0;
        if (c) mv = 0;
        else if (l) begin
            mv = bcd2int(lv);
            me = any_bad(lv);
        end else if (e) begin
            if (d && mv == MAXV) begin
                mw = 1'b1;
`ifndef BCD_SATURATE_EN
                mv = 0;
`endif
            end else if (!d && mv == 0) begin
                mw = 1'b1;
`ifndef BCD_SATURATE_EN
                mv = MAXV;
`endif
            end else mv = d ? mv + 1 : mv - 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.clr = 0; bus.load = 0; bus.load_val = '0; bus.en = 0; bus.dir = 0;
        #3;
        check_all("reset");
        #10 rst_n = 1'b1;
        @(negedge clk);
        repeat (3) cyc("up3", 0, 0, '0, 1, 1);
        cyc("load199", 0, 1, 16'h0199, 0, 0);
        cyc("carry200", 0, 0, '0, 1, 1);
        cyc("borrow199", 0, 0, '0, 1, 0);
        cyc("load9999", 0, 1, 16'h9999, 0, 0);
        cyc("wrap_up", 0, 0, '0, 1, 1);
        cyc("wrap_up_idle", 0, 0, '0, 0, 1);
        cyc("clr0", 0, 1, 16'h0000, 0, 0);
        cyc("wrap_down", 0, 0, '0, 1, 0);
        cyc("wrap_down_idle", 0, 0, '0, 0, 0);
        cyc("load_bad", 0, 1, 16'h3A7F, 0, 0);
        cyc("load_bad_idle", 0, 0, '0, 0, 0);
        cyc("load4321", 0, 1, 16'h4321, 0, 0);
        cyc("clr_prio", 1, 1, 16'h1234, 1, 1);
        cyc("load_prio", 0, 1, 16'h0055, 1, 1);
        cyc("dir_flip", 0, 0, '0, 1, 0);
        for (int k = 0; k < 400; k++) begin
            logic [15:0] lv;
            int sel;
            sel = int'($urandom_range(0, 5));
            lv  = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : (sel == 2) ? 16'($urandom) :
                  int2bcd(int'($urandom_range(0, MAXV)));
            cyc("rand", $urandom_range(0, 31) == 0, $urandom_range(0, 9) == 0, lv,
                $urandom_range(0, 3) != 0, 1'($urandom));
        end
        cyc("pre_rst_load", 0, 1, 16'h0042, 0, 0);
        bus.en = 1; bus.dir = 1; bus.load = 0; bus.clr = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mv = 0; mw = 0; me = 0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 0, 0, '0, 1, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
